// File: rtl/multicycle_ctrl.sv
// Control FSM for a multicycle RV32I core: sequences fetch, decode, execute,
// memory and writeback steps, one instruction in flight.
module multicycle_ctrl #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               run,
    input  logic [6:0]         opcode,
    input  logic [2:0]         funct3,
    input  logic               alu_zero,
    input  logic               alu_lt,
    input  logic               alu_ltu,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic               ir_write,
    output logic               pc_write,
    output logic               pc_sel,
    output logic               reg_write,
    output logic [1:0]         wb_sel,
    output logic               trap,
    output logic [STATE_W-1:0] state_o
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_EXEC_R  = 4'd3,
        S_EXEC_I  = 4'd4,
        S_MEMADDR = 4'd5,
        S_MEMRD   = 4'd6,
        S_MEMWR   = 4'd7,
        S_WB_ALU  = 4'd8,
        S_WB_MEM  = 4'd9,
        S_BRANCH  = 4'd10,
        S_JAL     = 4'd11,
        S_JALR    = 4'd12,
        S_HALT    = 4'd15
    } state_e;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    state_e     state_q, state_d;
    logic       trap_q, trap_d;
    logic       br_taken, br_illegal;
    logic [1:0] exec_src_a, exec_src_b;

    // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        br_taken   = 1'b0;
        br_illegal = 1'b0;
        case (funct3)
            3'b000:  br_taken = alu_zero;
            3'b001:  br_taken = !alu_zero;
            3'b100:  br_taken = alu_lt;
            3'b101:  br_taken = !alu_lt;
            3'b110:  br_taken = alu_ltu;
            3'b111:  br_taken = !alu_ltu;
            default: br_illegal = 1'b1;
        endcase
    end

    // Operand selection shared by EXEC_* and WB_ALU so the ALU result stays stable during writeback.
    always_comb begin
        exec_src_a = 2'b01;
        exec_src_b = 2'b01;
        case (opcode)
            OP_R:     exec_src_b = 2'b00;
            OP_LUI:   exec_src_a = 2'b11;
            OP_AUIPC: exec_src_a = 2'b10;
            default:  ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        trap_d  = trap_q;
        case (state_q)
            S_IDLE:   if (run) state_d = S_FETCH;
            S_FETCH:  if (mem_ready) state_d = run ? S_DECODE : S_IDLE;
            S_DECODE: begin
                case (opcode)
                    OP_R:                     state_d = S_EXEC_R;
                    OP_IMM, OP_LUI, OP_AUIPC: state_d = S_EXEC_I;
                    OP_LOAD, OP_STORE:        state_d = S_MEMADDR;
                    OP_BR:                    state_d = S_BRANCH;
                    OP_JAL:                   state_d = S_JAL;
                    OP_JALR:                  state_d = S_JALR;
                    default: begin
                        trap_d  = 1'b1;
                        state_d = S_HALT;
                    end
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
            S_MEMADDR: state_d = (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   if (mem_ready) state_d = S_WB_MEM;
            S_MEMWR:   if (mem_ready) state_d = S_FETCH;
            S_BRANCH: begin
                if (br_illegal) begin
                    trap_d  = 1'b1;
                    state_d = S_HALT;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_WB_ALU, S_WB_MEM, S_JAL, S_JALR: state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: reset is synchronous and active-high; it is only seen on a rising clock edge.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (resetn) begin
            state_q <= S_IDLE;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            trap_q  <= trap_d;
        end
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        alu_src_a = 2'b00;
        alu_src_b = 2'b00;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_sel    = 1'b0;
        reg_write = 1'b0;
        wb_sel    = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b10;
                ir_write  = mem_ready && run;
                pc_write  = mem_ready && run;
            end
            S_DECODE: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_EXEC_R: alu_src_a = 2'b01;
            S_EXEC_I: begin
                alu_src_a = exec_src_a;
                alu_src_b = exec_src_b;
            end
            S_WB_ALU: begin
                alu_src_a = exec_src_a;
                alu_src_b = exec_src_b;
                reg_write = 1'b1;
            end
            S_MEMADDR: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMRD, S_MEMWR: begin
                mem_req   = 1'b1;
                mem_we    = (state_q == S_MEMWR);
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_WB_MEM: begin
                reg_write = 1'b1;
                wb_sel    = 2'b01;
            end
            S_BRANCH: begin
                alu_src_a = 2'b01;
                pc_write  = br_taken && !br_illegal;
            end
            S_JAL: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                pc_write  = 1'b1;
                reg_write = 1'b1;
                wb_sel    = 2'b10;
            end
            S_JALR: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                pc_write  = 1'b1;
                pc_sel    = 1'b1;
                reg_write = 1'b1;
                wb_sel    = 2'b10;
            end
            default: ;
        endcase
    end

    assign trap    = trap_q;
    assign state_o = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed cycle table, then random
// stimulus against an instruction-plan reference model.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       req;
        logic       we;
        logic [1:0] sa;
        logic [1:0] sb;
        logic       irw;
        logic       pcw;
        logic       pcs;
        logic       rw;
        logic [1:0] wb;
        logic       trp;
    } outv_t;

    typedef struct {
        logic       rst;
        logic       rn;
        logic [6:0] op;
        logic [2:0] f3;
        logic       z;
        logic       rdy;
        logic [3:0] st;
        outv_t      out;
    } vec_t;

    localparam logic [6:0] R   = 7'b0110011;
    localparam logic [6:0] LUI = 7'b0110111;
    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] JLR = 7'b1100111;
    localparam logic [6:0] BAD = 7'b0000000;

    logic       clk = 1'b0;
    logic       resetn = 1'b1, run = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       alu_zero = 1'b0, alu_lt = 1'b0, alu_ltu = 1'b0, mem_ready = 1'b0;
    logic       mem_req, mem_we, ir_write, pc_write, pc_sel, reg_write, trap;
    logic [1:0] alu_src_a, alu_src_b, wb_sel;
    logic [3:0] state_o;

    int errors = 0;
    int checks = 0;

    vec_t       vecs[$];
    outv_t      base_tab[16];
    logic [6:0] legal_ops[9] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111,
                                 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111};
    int         ms, halt_cyc;
    logic       mtrap;
    int         plan[$];

    multicycle_ctrl #(.STATE_W(4)) dut (
        .clk(clk), .resetn(resetn), .run(run), .opcode(opcode), .funct3(funct3),
        .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .ir_write(ir_write), .pc_write(pc_write), .pc_sel(pc_sel), .reg_write(reg_write),
        .wb_sel(wb_sel), .trap(trap), .state_o(state_o)
    );

    always #5 clk = ~clk;

    function automatic outv_t o(logic req, logic we, logic [1:0] sa, logic [1:0] sb, logic irw,
                                logic pcw, logic pcs, logic rw, logic [1:0] wb, logic trp);
        return '{req, we, sa, sb, irw, pcw, pcs, rw, wb, trp};
    endfunction

    function automatic outv_t dut_out();
        return {mem_req, mem_we, alu_src_a, alu_src_b, ir_write, pc_write, pc_sel,
                reg_write, wb_sel, trap};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic rn, input logic [6:0] op, input logic [2:0] f3,
                       input logic z, input logic rdy, input logic [3:0] st, input outv_t out);
        vec_t v;
        v.rst = rst; v.rn = rn; v.op = op; v.f3 = f3; v.z = z; v.rdy = rdy; v.st = st; v.out = out;
        vecs.push_back(v);
    endtask

    // Reference outputs: a per-state table plus the few input-dependent overlays.
    function automatic outv_t model_out(int st, logic trp, logic rn, logic rdy);
        outv_t e = base_tab[st];
        logic  tk;
        if (st == 1) begin
            e.irw = rdy && rn;
            e.pcw = rdy && rn;
        end
        if (st == 4 || st == 8) begin
            if (opcode == 7'b0110011)      begin e.sa = 2'b01; e.sb = 2'b00; end
            else if (opcode == 7'b0110111) begin e.sa = 2'b11; e.sb = 2'b01; end
            else if (opcode == 7'b0010111) begin e.sa = 2'b10; e.sb = 2'b01; end
            else                           begin e.sa = 2'b01; e.sb = 2'b01; end
        end
        if (st == 10) begin
            case (funct3)
                3'd0: tk = alu_zero;
                3'd1: tk = !alu_zero;
                3'd4: tk = alu_lt;
                3'd5: tk = !alu_lt;
                3'd6: tk = alu_ltu;
                3'd7: tk = !alu_ltu;
                default: tk = 1'b0;
            endcase
            e.pcw = tk;
        end
        e.trp = trp;
        return e;
    endfunction

    task automatic advance();
        if (plan.size() != 0) ms = plan.pop_front();
        else ms = 1;
    endtask

    initial begin
        outv_t f_rdy, f_wait, dec;
        f_rdy  = o(1, 0, 2'b00, 2'b10, 1, 1, 0, 0, 2'b00, 0);
        f_wait = o(1, 0, 2'b00, 2'b10, 0, 0, 0, 0, 2'b00, 0);
        dec    = o(0, 0, 2'b10, 2'b01, 0, 0, 0, 0, 2'b00, 0);

        // R-type, memory always ready
        add(0, 1, R, 0, 0, 1, 0, '0);
        add(0, 1, R, 0, 0, 1, 1, f_rdy);
        add(0, 1, R, 0, 0, 1, 2, dec);
        add(0, 1, R, 0, 0, 1, 3, o(0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 0));
        add(0, 1, R, 0, 0, 1, 8, o(0, 0, 2'b01, 2'b00, 0, 0, 0, 1, 2'b00, 0));
        // load with three wait cycles in MEMRD
        add(0, 1, LD, 0, 0, 1, 1, f_rdy);
        add(0, 1, LD, 0, 0, 1, 2, dec);
        add(0, 1, LD, 0, 0, 0, 5, o(0, 0, 2'b01, 2'b01, 0, 0, 0, 0, 2'b00, 0));
        for (int i = 0; i < 3; i++)
            add(0, 1, LD, 0, 0, 0, 6, o(1, 0, 2'b01, 2'b01, 0, 0, 0, 0, 2'b00, 0));
        add(0, 1, LD, 0, 0, 1, 6, o(1, 0, 2'b01, 2'b01, 0, 0, 0, 0, 2'b00, 0));
        add(0, 1, LD, 0, 0, 1, 9, o(0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 2'b01, 0));
        // BEQ taken, then not taken
        add(0, 1, BR, 0, 0, 1, 1, f_rdy);
        add(0, 1, BR, 0, 0, 1, 2, dec);
        add(0, 1, BR, 0, 1, 1, 10, o(0, 0, 2'b01, 2'b00, 0, 1, 0, 0, 2'b00, 0));
        add(0, 1, BR, 0, 0, 1, 1, f_rdy);
        add(0, 1, BR, 0, 0, 1, 2, dec);
        add(0, 1, BR, 0, 0, 1, 10, o(0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 0));
        // JALR, JAL, LUI
        add(0, 1, JLR, 0, 0, 1, 1, f_rdy);
        add(0, 1, JLR, 0, 0, 1, 2, dec);
        add(0, 1, JLR, 0, 0, 1, 12, o(0, 0, 2'b01, 2'b01, 0, 1, 1, 1, 2'b10, 0));
        add(0, 1, JAL, 0, 0, 1, 1, f_rdy);
        add(0, 1, JAL, 0, 0, 1, 2, dec);
        add(0, 1, JAL, 0, 0, 1, 11, o(0, 0, 2'b10, 2'b01, 0, 1, 0, 1, 2'b10, 0));
        add(0, 1, LUI, 0, 0, 1, 1, f_rdy);
        add(0, 1, LUI, 0, 0, 1, 2, dec);
        add(0, 1, LUI, 0, 0, 1, 4, o(0, 0, 2'b11, 2'b01, 0, 0, 0, 0, 2'b00, 0));
        add(0, 1, LUI, 0, 0, 1, 8, o(0, 0, 2'b11, 2'b01, 0, 0, 0, 1, 2'b00, 0));
        // store interrupted by reset while mem_req is pending
        add(0, 1, ST, 0, 0, 1, 1, f_rdy);
        add(0, 1, ST, 0, 0, 1, 2, dec);
        add(0, 1, ST, 0, 0, 0, 5, o(0, 0, 2'b01, 2'b01, 0, 0, 0, 0, 2'b00, 0));
        add(0, 1, ST, 0, 0, 0, 7, o(1, 1, 2'b01, 2'b01, 0, 0, 0, 0, 2'b00, 0));
        add(1, 1, ST, 0, 0, 0, 7, o(1, 1, 2'b01, 2'b01, 0, 0, 0, 0, 2'b00, 0));
        add(0, 0, ST, 0, 0, 1, 0, '0);
        // illegal opcode, fetch stall first
        add(0, 1, BAD, 0, 0, 1, 0, '0);
        add(0, 1, BAD, 0, 0, 0, 1, f_wait);
        add(0, 1, BAD, 0, 0, 1, 1, f_rdy);
        add(0, 1, BAD, 0, 0, 1, 2, dec);
        add(0, 1, BAD, 0, 1, 1, 15, o(0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 1));
        add(0, 1, R,   0, 1, 1, 15, o(0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 1));
        add(1, 1, R,   0, 1, 1, 15, o(0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 1));
        add(0, 0, R,   0, 0, 0, 0, '0);

        for (int i = 0; i < 16; i++) base_tab[i] = '0;
        base_tab[1]  = f_wait;
        base_tab[2]  = dec;
        base_tab[3]  = o(0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 0);
        base_tab[8]  = o(0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 2'b00, 0);
        base_tab[5]  = o(0, 0, 2'b01, 2'b01, 0, 0, 0, 0, 2'b00, 0);
        base_tab[6]  = o(1, 0, 2'b01, 2'b01, 0, 0, 0, 0, 2'b00, 0);
        base_tab[7]  = o(1, 1, 2'b01, 2'b01, 0, 0, 0, 0, 2'b00, 0);
        base_tab[9]  = o(0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 2'b01, 0);
        base_tab[10] = o(0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 0);
        base_tab[11] = o(0, 0, 2'b10, 2'b01, 0, 1, 0, 1, 2'b10, 0);
        base_tab[12] = o(0, 0, 2'b01, 2'b01, 0, 1, 1, 1, 2'b10, 0);

        resetn = 1'b1;
        repeat (2) @(negedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            resetn = vecs[i].rst; run = vecs[i].rn; opcode = vecs[i].op; funct3 = vecs[i].f3;
            alu_zero = vecs[i].z; alu_lt = 1'b0; alu_ltu = 1'b0; mem_ready = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d state", i), 32'(state_o), 32'(vecs[i].st));
            check($sformatf("vec%0d outputs", i), 32'(dut_out()), 32'(vecs[i].out));
        end

        ms = 0; mtrap = 1'b0; halt_cyc = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            resetn = (c == 0) || ($urandom_range(0, 59) == 0) || (ms == 15 && halt_cyc >= 3);
            if (ms == 0 || ms == 1) begin
                run = ($urandom_range(0, 7) != 0);
                if ($urandom_range(0, 5) == 0) opcode = 7'($urandom_range(0, 127));
                else opcode = legal_ops[$urandom_range(0, 8)];
                funct3 = 3'($urandom_range(0, 7));
            end else begin
                run = 1'($urandom_range(0, 1));
            end
            alu_zero  = 1'($urandom_range(0, 1));
            alu_lt    = 1'($urandom_range(0, 1));
            alu_ltu   = 1'($urandom_range(0, 1));
            mem_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (c > 0) begin
                check($sformatf("rnd%0d state", c), 32'(state_o), 32'(ms));
                check($sformatf("rnd%0d outputs", c), 32'(dut_out()),
                      32'(model_out(ms, mtrap, run, mem_ready)));
            end
            if (resetn) begin
                ms = 0; mtrap = 1'b0; plan.delete();
            end else begin
                case (ms)
                    0: if (run) ms = 1;
                    1: if (mem_ready) ms = run ? 2 : 0;
                    2: begin
                        plan.delete();
                        case (opcode)
                            7'b0110011:                         plan = '{3, 8};
                            7'b0010011, 7'b0110111, 7'b0010111: plan = '{4, 8};
                            7'b0000011:                         plan = '{5, 6, 9};
                            7'b0100011:                         plan = '{5, 7};
                            7'b1100011:                         plan = '{10};
                            7'b1101111:                         plan = '{11};
                            7'b1100111:                         plan = '{12};
                            default: ;
                        endcase
                        if (plan.size() == 0) begin mtrap = 1'b1; ms = 15; end
                        else ms = plan.pop_front();
                    end
                    6, 7: if (mem_ready) advance();
                    10: if (funct3 == 3'd2 || funct3 == 3'd3) begin mtrap = 1'b1; ms = 15; end
                        else advance();
                    15: ;
                    default: advance();
                endcase
            end
            halt_cyc = (ms == 15) ? halt_cyc + 1 : 0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
